serial_to_parallel_hs: RTL and testbench

//  Parametrised deserialiser; successor to the fixed 32-bit serial_to_parallel.

---
 rtl/serial_to_parallel_hs_if.sv | 28 ++
 rtl/serial_to_parallel_hs.sv | 80 ++++++++
 tb/tb_serial_to_parallel_hs.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_hs_if.sv
// Bundle of the serial-side inputs and the parallel-side valid/ready handshake.
// The slave modport is the deserialiser's view; master is the driving side.
interface serial_to_parallel_hs_if #(
    parameter int WIDTH = 32
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             serial_in;
    logic             bit_valid;
    logic             frame_start;
    logic             msb_first;
    logic             out_ready;
    logic             overrun_clr;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             overrun;
    logic [CNT_W-1:0] bit_count;

    modport slave (
        input  serial_in, bit_valid, frame_start, msb_first, out_ready, overrun_clr,
        output parallel_out, out_valid, overrun, bit_count
    );

    modport master (
        output serial_in, bit_valid, frame_start, msb_first, out_ready, overrun_clr,
        input  parallel_out, out_valid, overrun, bit_count
    );
endinterface

// File: rtl/serial_to_parallel_hs.sv
// Parametrised deserialiser: assembles WIDTH serial bits (MSB- or LSB-first) into a
// word held in a one-deep valid/ready output register, with resync and sticky overrun.
module serial_to_parallel_hs #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_to_parallel_hs_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] holding;
    logic [CNT_W-1:0] count;
    logic             mode;
    logic             mode_now;
    logic             valid_q;
    logic             overrun_q;
    logic             complete;
    logic             slot_free;

    // A word's first bit (or a resync bit) takes the live msb_first; later bits use the latched mode.
    always_comb begin
        mode_now  = ((count == '0) || bus.frame_start) ? bus.msb_first : mode;
        base      = bus.frame_start ? '0 : sr;
        sr_next   = mode_now ? {base[WIDTH-2:0], bus.serial_in}
                             : {bus.serial_in, base[WIDTH-1:1]};
        complete  = bus.bit_valid && !bus.frame_start && (count == LAST);
        slot_free = !valid_q || bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr        <= '0;
            count     <= '0;
            mode      <= 1'b0;
            holding   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.bit_valid) begin
                sr <= sr_next;
                if (bus.frame_start) begin
                    count <= CNT_W'(1);
                end else if (complete) begin
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
                if ((count == '0) || bus.frame_start) begin
                    mode <= bus.msb_first;
                end
            end else if (bus.frame_start) begin
                count <= '0;
            end

            // A completion landing on the same edge as an accept refills the slot without a gap.
            if (complete && slot_free) begin
                holding <= sr_next;
                valid_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end

            if (complete && !slot_free) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.parallel_out = holding;
    assign bus.out_valid    = valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.bit_count    = count;
endmodule

// File: tb/tb_serial_to_parallel_hs.sv
// Directed bench for serial_to_parallel_hs (WIDTH=8): a bit-queue reference model is
// compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_serial_to_parallel_hs;
    localparam int W = 8;

    logic clk;
    logic reset;

    serial_to_parallel_hs_if #(.WIDTH(W)) bus ();

    serial_to_parallel_hs #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int check_count = 0;
    int pass_count  = 0;

    // Reference model: bits of the partial word in arrival order, plus the holding slot.
    logic     model_bits[$];
    logic     m_mode;
    logic [7:0] m_out;
    logic     m_valid;
    logic     m_ovr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input logic sv, input logic bv, input logic fs, input logic mf,
                             input logic rdy, input logic clr, input logic rst);
        logic       done;
        logic       free;
        logic [7:0] word;
        done = 1'b0;
        word = '0;
        if (!rst) begin
            model_bits.delete();
            m_mode  = 1'b0;
            m_out   = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        if (bv) begin
            if (fs) model_bits.delete();
            if (model_bits.size() == 0) m_mode = mf;
            model_bits.push_back(sv);
            if (model_bits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    if (model_bits[i]) word[m_mode ? (W - 1 - i) : i] = 1'b1;
                end
                done = 1'b1;
                model_bits.delete();
            end
        end else if (fs) begin
            model_bits.delete();
        end
        free = !m_valid || rdy;
        if (done && free) begin
            m_out   = word;
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (done && !free) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic checkOutput();
        checkValue("parallel_out", int'(bus.parallel_out), int'(m_out));
        checkValue("out_valid", int'(bus.out_valid), int'(m_valid));
        checkValue("overrun", int'(bus.overrun), int'(m_ovr));
        checkValue("bit_count", int'(bus.bit_count), model_bits.size());
    endtask

    // Drive one cycle of inputs, let the edge happen, then step the model and compare.
    task automatic applyStimulus(input logic sv, input logic bv, input logic fs, input logic mf,
                                 input logic rdy, input logic clr, input logic rst);
        bus.serial_in   = sv;
        bus.bit_valid   = bv;
        bus.frame_start = fs;
        bus.msb_first   = mf;
        bus.out_ready   = rdy;
        bus.overrun_clr = clr;
        reset           = rst;
        @(posedge clk);
        #1;
        modelStep(sv, bv, fs, mf, rdy, clr, rst);
        checkOutput();
    endtask

    // Sends seq[7] first down to seq[0]; ready is rdy_mid except on the last bit (rdy_last).
    task automatic sendBits(input logic [7:0] seq, input logic mf, input logic toggle,
                            input logic rdy_mid, input logic rdy_last);
        for (int i = 0; i < W; i++) begin
            applyStimulus(seq[W - 1 - i], 1'b1, 1'b0, toggle ? (mf ^ i[0]) : mf,
                          (i == W - 1) ? rdy_last : rdy_mid, 1'b0, 1'b1);
        end
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b1);
    endtask

    initial begin
        int valid_cycles;
        logic [7:0] a5;
        m_mode  = 1'b0;
        m_out   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        a5      = 8'hA5;

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkValue("reset parallel_out", int'(bus.parallel_out), 0);
        checkValue("reset out_valid", int'(bus.out_valid), 0);
        checkValue("reset bit_count", int'(bus.bit_count), 0);

        $display("[TB] MSB-first word");
        sendBits(8'b1011_0010, 1'b1, 1'b0, 1'b1, 1'b1);
        checkValue("msb word", int'(bus.parallel_out), 'hB2);
        checkValue("msb valid pulse", int'(bus.out_valid), 1);
        idle(1'b1);
        checkValue("msb valid one cycle", int'(bus.out_valid), 0);
        checkValue("msb word held", int'(bus.parallel_out), 'hB2);

        $display("[TB] LSB-first word and mid-word mode toggle");
        sendBits(8'b1011_0010, 1'b0, 1'b0, 1'b1, 1'b1);
        checkValue("lsb word", int'(bus.parallel_out), 'h4D);
        idle(1'b1);
        sendBits(8'b1011_0010, 1'b0, 1'b1, 1'b1, 1'b1);
        checkValue("lsb toggled word", int'(bus.parallel_out), 'h4D);
        idle(1'b1);

        $display("[TB] Overrun with consumer stalled");
        sendBits(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0);
        sendBits(8'h4D, 1'b1, 1'b0, 1'b0, 1'b0);
        checkValue("stalled word", int'(bus.parallel_out), 'hB2);
        checkValue("stalled valid", int'(bus.out_valid), 1);
        checkValue("overrun set", int'(bus.overrun), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkValue("overrun cleared", int'(bus.overrun), 0);
        idle(1'b1);
        checkValue("accepted valid", int'(bus.out_valid), 0);

        $display("[TB] Frame resync");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(a5[7], 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkValue("resync bit_count", int'(bus.bit_count), 1);
        for (int i = 6; i >= 0; i--) applyStimulus(a5[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkValue("resync word", int'(bus.parallel_out), 'hA5);
        checkValue("resync no overrun", int'(bus.overrun), 0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkValue("bare resync bit_count", int'(bus.bit_count), 0);

        $display("[TB] Back-to-back stream, accept on completion edge");
        valid_cycles = 0;
        for (int k = 1; k <= 16; k++) begin
            for (int i = 0; i < W; i++) begin
                logic [7:0] w;
                w = 8'(k);
                applyStimulus(w[W - 1 - i], 1'b1, 1'b0, 1'b1, (i == W - 1), 1'b0, 1'b1);
                if (bus.out_valid && i == W - 1) valid_cycles++;
            end
        end
        checkValue("stream deliveries", valid_cycles, 16);
        checkValue("stream last word", int'(bus.parallel_out), 'h10);
        checkValue("stream no overrun", int'(bus.overrun), 0);
        idle(1'b1);

        $display("[TB] Reset mid-word and against completion");
        sendBits(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        sendBits(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkValue("mid reset parallel_out", int'(bus.parallel_out), 0);
        checkValue("mid reset overrun", int'(bus.overrun), 0);
        checkValue("mid reset bit_count", int'(bus.bit_count), 0);
        sendBits(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        checkValue("clean word after reset", int'(bus.parallel_out), 'h3C);
        idle(1'b1);
        sendBits(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        sendBits(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkValue("reset vs completion valid", int'(bus.out_valid), 0);
        checkValue("reset vs completion word", int'(bus.parallel_out), 0);
        checkValue("reset vs overrun", int'(bus.overrun), 0);
        idle(1'b1);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
